// File: rtl/fp_interp_classifier.sv
// ---------------------------------------------------------------------------
// fp_interp_classifier
//   Reads an IEEE-754 single and classifies it into float_interpretations::
//   interp_t (ZERO/INF/NORM/MIN_NORM/MAX_NORM), flagging NaN and denormal
//   inputs. Two-stage valid/ready pipeline: S1 holds the raw word, S2 holds
//   the class, sign and flags.
//
//   Optional feature macro: FP_CLASS_STATS_EN (adds per-class saturating
//   counters, the COUNT_W parameter and the stats_clr input).
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-low reset
//   in_valid   in   in_float is valid
//   in_ready   out  block accepts in_float this cycle
//   in_float   in   {sign, exp[7:0], mant[22:0]}
//   out_valid  out  result outputs are valid
//   out_ready  in   downstream accepts the result
//   out_interp out  interp_t class (3-bit encoding from the package)
//   out_sign   out  sign bit of the input
//   out_nan    out  input was NaN (class reported as INF)
//   out_denorm out  input was denormal (class reported as ZERO)
//   stats_clr  in   synchronous clear of all counters        (stats build)
//   cnt_*      out  per-class transfer counts, saturating     (stats build)
// ---------------------------------------------------------------------------
package float_interpretations;
    typedef enum logic [2:0] {
        ZERO     = 3'd0,
        INF      = 3'd1,
        NORM     = 3'd2,
        MIN_NORM = 3'd3,
        MAX_NORM = 3'd4
    } interp_t;
endpackage

module fp_interp_classifier
`ifdef FP_CLASS_STATS_EN
#(
    parameter int COUNT_W = 16
)
`endif
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_float,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_interp,
    output logic              out_sign,
    output logic              out_nan,
    output logic              out_denorm
`ifdef FP_CLASS_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [COUNT_W-1:0] cnt_zero,
    output logic [COUNT_W-1:0] cnt_inf,
    output logic [COUNT_W-1:0] cnt_norm,
    output logic [COUNT_W-1:0] cnt_min,
    output logic [COUNT_W-1:0] cnt_max
`endif
);
    import float_interpretations::*;

    // State encoding is {s1_valid, s2_valid}.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_S1    = 2'b10,
        ST_BOTH  = 2'b11,
        ST_S2    = 2'b01
    } st_t;

    st_t         r_state;
    st_t         w_state_nxt;
    logic        r_rdy_en;       // holds in_ready low for the first cycle after reset
    logic        w_s1_valid;
    logic        w_s2_valid;
    logic        w_adv2;
    logic        w_acc;

    logic [31:0] r_s1_data;
    logic [2:0]  r_s2_interp;
    logic        r_s2_sign;
    logic        r_s2_nan;
    logic        r_s2_denorm;

    interp_t     w_cls;
    logic        w_nan;
    logic        w_denorm;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_EMPTY;
            r_rdy_en <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rdy_en <= 1'b1;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: w_state_nxt = w_acc ? ST_S1 : ST_EMPTY;
            // S2 is empty, so S1 always moves down
            ST_S1:    w_state_nxt = w_acc ? ST_BOTH : ST_S2;
            ST_BOTH:  if (out_ready) w_state_nxt = w_acc ? ST_BOTH : ST_S2;
            ST_S2:    if (out_ready) w_state_nxt = w_acc ? ST_S1 : ST_EMPTY;
                      else           w_state_nxt = w_acc ? ST_BOTH : ST_S2;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // ---------------- outputs / handshake ----------------
    always_comb begin
        w_s1_valid = r_state[1];
        w_s2_valid = r_state[0];
        w_adv2     = !w_s2_valid || out_ready;
        in_ready   = r_rdy_en && (!w_s1_valid || w_adv2);
        w_acc      = in_valid && in_ready;
        out_valid  = w_s2_valid;
    end

    // ---------------- classification of the S1 word ----------------
    always_comb begin
        w_cls    = NORM;
        w_nan    = 1'b0;
        w_denorm = 1'b0;
        if (r_s1_data[30:23] == 8'hFF) begin
            w_cls = INF;
            w_nan = (r_s1_data[22:0] != 23'd0);
        end else if (r_s1_data[30:23] == 8'h00) begin
            w_cls    = ZERO;
            w_denorm = (r_s1_data[22:0] != 23'd0);
        end else if (r_s1_data[30:23] == 8'h01 && r_s1_data[22:0] == 23'd0) begin
            w_cls = MIN_NORM;
        end else if (r_s1_data[30:23] == 8'hFE && r_s1_data[22:0] == '1) begin
            w_cls = MAX_NORM;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_data   <= 32'd0;
            r_s2_interp <= ZERO;
            r_s2_sign   <= 1'b0;
            r_s2_nan    <= 1'b0;
            r_s2_denorm <= 1'b0;
        end else begin
            if (w_acc)
                r_s1_data <= in_float;
            if (w_adv2 && w_s1_valid) begin
                r_s2_interp <= w_cls;
                r_s2_sign   <= r_s1_data[31];
                r_s2_nan    <= w_nan;
                r_s2_denorm <= w_denorm;
            end
        end
    end

    assign out_interp = r_s2_interp;
    assign out_sign   = r_s2_sign;
    assign out_nan    = r_s2_nan;
    assign out_denorm = r_s2_denorm;

`ifdef FP_CLASS_STATS_EN
    // One counter per class, indexed by the interp_t encoding.
    logic [COUNT_W-1:0] r_cnt [5];
    logic               w_out_xfer;

    assign w_out_xfer = w_s2_valid && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 5; k++) r_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 5; k++) begin
                if (stats_clr)
                    r_cnt[k] <= '0;
                else if (w_out_xfer && r_s2_interp == 3'(k) && r_cnt[k] != '1)
                    r_cnt[k] <= r_cnt[k] + COUNT_W'(1);
            end
        end
    end

    assign cnt_zero = r_cnt[0];
    assign cnt_inf  = r_cnt[1];
    assign cnt_norm = r_cnt[2];
    assign cnt_min  = r_cnt[3];
    assign cnt_max  = r_cnt[4];
`endif

endmodule

// File: tb/tb_fp_interp_classifier.sv
// ---------------------------------------------------------------------------
// tb_fp_interp_classifier
//   Directed and randomized stimulus for fp_interp_classifier. Expected
//   results come from a magnitude-based reference classifier and an
//   in-order scoreboard queue. Stats checks use COUNT_W=2 and are built only
//   when FP_CLASS_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_fp_interp_classifier;
    import float_interpretations::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        stats_clr = 1'b0;
    logic [31:0] in_float = 32'd0;
    logic        in_ready, out_valid, out_sign, out_nan, out_denorm;
    logic [2:0]  out_interp;
`ifdef FP_CLASS_STATS_EN
    logic [1:0]  cnt_zero, cnt_inf, cnt_norm, cnt_min, cnt_max;
`endif

`ifdef FP_CLASS_STATS_EN
    fp_interp_classifier #(.COUNT_W(2)) dut (
`else
    fp_interp_classifier dut (
`endif
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_float(in_float),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_interp(out_interp), .out_sign(out_sign),
        .out_nan(out_nan), .out_denorm(out_denorm)
`ifdef FP_CLASS_STATS_EN
        , .stats_clr(stats_clr),
        .cnt_zero(cnt_zero), .cnt_inf(cnt_inf), .cnt_norm(cnt_norm),
        .cnt_min(cnt_min), .cnt_max(cnt_max)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    typedef struct { logic [31:0] d; int acc; } ent_t;
    ent_t q[$];

    int   errors = 0, checks = 0, cyc = 0, delivered = 0;
    bit   chk_lat = 1'b0, prev_stall = 1'b0, clr_req = 1'b0, last_acc = 1'b0;
    logic [5:0] prev_out;
    wire  [5:0] outs = {out_interp, out_sign, out_nan, out_denorm};

    // Reference: classify by the magnitude of the word.
    function automatic logic [5:0] model(input logic [31:0] x);
        logic [30:0] a;
        interp_t     c;
        a = x[30:0];
        if      (a >= 31'h7F800000) c = INF;
        else if (a <  31'h00800000) c = ZERO;
        else if (a == 31'h00800000) c = MIN_NORM;
        else if (a == 31'h7F7FFFFF) c = MAX_NORM;
        else                        c = NORM;
        return {c, x[31], a > 31'h7F800000, (a != 0) && (a < 31'h00800000)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs at negedge, score the transfers that the next
    // posedge will perform.
    task automatic step(input logic v, input logic [31:0] d, input logic rdy);
        ent_t e;
        @(negedge clk);
        in_valid  = v;
        in_float  = d;
        out_ready = rdy;
        stats_clr = clr_req;
        #1;
        if (prev_stall) chk("stall_hold", 32'(outs), 32'(prev_out));
        if (out_valid && out_ready) begin
            if (q.size() == 0) chk("unexpected_out", 32'(outs), 32'hFFFFFFFF);
            else begin
                e = q.pop_front();
                chk("result", 32'(outs), 32'(model(e.d)));
                if (chk_lat) chk("latency", cyc - e.acc, 2);
                delivered++;
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = outs;
        last_acc   = in_valid && in_ready;
        if (last_acc) q.push_back('{d: d, acc: cyc});
        cyc++;
    endtask

    logic [31:0] t1_in [5] = '{32'h00000000, 32'h7F800000, 32'h3F800000, 32'h00800000, 32'h7F7FFFFF};
    logic [2:0]  t1_cls[5] = '{ZERO, INF, NORM, MIN_NORM, MAX_NORM};
    logic [31:0] t3_in [6] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 32'h00800000, 32'h7F7FFFFF, 32'h40490FDB};
    logic [31:0] t6_in [4] = '{32'h00FFFFFF, 32'h7F7FFFFE, 32'h7F000000, 32'hFF800001};
    logic [5:0]  t6_exp[4] = '{{NORM, 3'b000}, {NORM, 3'b000}, {NORM, 3'b000}, {INF, 3'b110}};

    initial begin
        int idx, n, start, sel;
        logic [31:0] r;

        // ---- reset state ----
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_outs", 32'(outs), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
`ifdef FP_CLASS_STATS_EN
        chk("rst_cnts", {22'd0, cnt_zero, cnt_inf, cnt_norm, cnt_min, cnt_max}, 0);
`endif
        rst = 1'b1;
        #1 chk("rel_in_ready_low", 32'(in_ready), 0);
        @(negedge clk);
        #1 chk("rel_in_ready_high", 32'(in_ready), 1);

        // ---- 1: basic stream, 2-cycle latency ----
        chk_lat = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step(i < 5, (i < 5) ? t1_in[i] : 32'd0, 1'b1);
            chk("t1_valid", 32'(out_valid), 32'(i >= 2));
            if (i >= 2) chk("t1_class", 32'(out_interp), 32'(t1_cls[i-2]));
        end

        // ---- 2: NaN and negative denormal ----
        step(1'b1, 32'h7FC00000, 1'b1);
        step(1'b1, 32'h80000001, 1'b1);
        step(1'b0, 32'd0, 1'b1);
        chk("t2_nan", 32'(outs), 32'({INF, 3'b010}));
        step(1'b0, 32'd0, 1'b1);
        chk("t2_denorm", 32'(outs), 32'({ZERO, 3'b101}));
        step(1'b0, 32'd0, 1'b1);

        // ---- 3: back-pressure then release ----
        chk_lat = 1'b0;
        idx = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, t3_in[idx], 1'b0);
            if (last_acc) idx++;
        end
        chk("t3_accepts", idx, 2);
        chk("t3_in_ready", 32'(in_ready), 0);
        start = delivered;
        n = 0;
        while (delivered < start + 6 && n < 20) begin
            step(idx < 6, (idx < 6) ? t3_in[idx] : 32'd0, 1'b1);
            if (last_acc) idx++;
            n++;
        end
        chk("t3_nogap", n, 6);

        // ---- 4: reset while full ----
        step(1'b1, 32'h7F800000, 1'b0);
        step(1'b1, 32'h7FC00001, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        chk("t4_full", 32'(out_valid), 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t4_rst_valid", 32'(out_valid), 0);
        chk("t4_rst_outs", 32'(outs), 0);
        q.delete();
        prev_stall = 1'b0;
        @(negedge clk) rst = 1'b1;
        #1 chk("t4_rel_in_ready", 32'(in_ready), 0);
        step(1'b0, 32'd0, 1'b1);
        chk("t4_in_ready", 32'(in_ready), 1);
        chk_lat = 1'b1;
        step(1'b1, 32'h3F800000, 1'b1);
        step(1'b0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 1'b1);
        chk("t4_norm", 32'(outs), 32'({NORM, 3'b000}));
        step(1'b0, 32'd0, 1'b1);
        chk("t4_empty", q.size(), 0);

        // ---- 6: boundaries ----
        for (int i = 0; i < 6; i++) begin
            step(i < 4, (i < 4) ? t6_in[i] : 32'd0, 1'b1);
            if (i >= 2) chk("t6_bound", 32'(outs), 32'(t6_exp[i-2]));
        end

        // ---- randomized stream with random back-pressure ----
        chk_lat = 1'b0;
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 5);
            r = $urandom;
            case (sel)
                1: r[30:23] = 8'hFF;
                2: r[30:23] = 8'h00;
                3: r[30:0]  = 31'h00800000;
                4: r[30:0]  = 31'h7F7FFFFF;
                5: r[30:23] = 8'hFE;
                default: ;
            endcase
            if ($urandom_range(0, 7) == 0) r[22:0] = 23'd0;
            step($urandom_range(0, 3) != 0, r, $urandom_range(0, 3) != 0);
        end
        n = 0;
        while (q.size() != 0 && n < 20) begin
            step(1'b0, 32'd0, 1'b1);
            n++;
        end
        chk("rand_drain", q.size(), 0);

`ifdef FP_CLASS_STATS_EN
        // ---- 5: saturating counters and clear priority ----
        clr_req = 1'b1;
        step(1'b0, 32'd0, 1'b1);
        clr_req = 1'b0;
        step(1'b0, 32'd0, 1'b1);
        chk("t5_clr", {22'd0, cnt_zero, cnt_inf, cnt_norm, cnt_min, cnt_max}, 0);
        repeat (5) step(1'b1, 32'h00000000, 1'b1);
        repeat (3) step(1'b0, 32'd0, 1'b1);
        chk("t5_sat", {22'd0, cnt_zero, cnt_inf, cnt_norm, cnt_min, cnt_max}, {22'd0, 2'd3, 8'd0});
        step(1'b1, 32'h7F800000, 1'b1);
        step(1'b0, 32'd0, 1'b1);
        clr_req = 1'b1;
        step(1'b0, 32'd0, 1'b1);
        chk("t5_clr_xfer_valid", 32'(out_valid), 1);
        clr_req = 1'b0;
        step(1'b0, 32'd0, 1'b1);
        chk("t5_clr_prio", {22'd0, cnt_zero, cnt_inf, cnt_norm, cnt_min, cnt_max}, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
